hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 53 +++++
 rtl/hazard_ctrl_mdu_latency_cnt.sv | 44 ++++
 rtl/hazard_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_pkg
//   Shared control encodings for the pipeline hazard controller:
//     - hazard FSM state encoding
//     - default latency / timeout parameter values
//     - DMRd (data-memory read type) and NPC (next-PC select) encodings
//     - load-use detection helper
// -----------------------------------------------------------------------------
package hazard_ctrl_pkg;

    // Default parameter values for hazard_ctrl
    localparam int MDU_LAT_DEF     = 32;
    localparam int MEM_TIMEOUT_DEF = 64;

    // Width of the MDU latency counter (holds MDU_LAT-1 for MDU_LAT <= 255)
    localparam int CNT_W = 8;
    localparam int REG_W = 5;

    // Hazard FSM states
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MDU_WAIT = 2'd1,
        ST_MEM_WAIT = 2'd2
    } hz_state_e;

    // Data-memory read type; anything other than DMRD_NOP is a load
    localparam logic [2:0] DMRD_NOP = 3'd0;
    localparam logic [2:0] DMRD_LW  = 3'd1;
    localparam logic [2:0] DMRD_LH  = 3'd2;
    localparam logic [2:0] DMRD_LHU = 3'd3;
    localparam logic [2:0] DMRD_LB  = 3'd4;
    localparam logic [2:0] DMRD_LBU = 3'd5;

    // Next-PC select
    localparam logic [1:0] NPC_PLUS4  = 2'd0;
    localparam logic [1:0] NPC_BRANCH = 2'd1;
    localparam logic [1:0] NPC_JUMP   = 2'd2;
    localparam logic [1:0] NPC_JREG   = 2'd3;

    // Load-use: the load in ID/EXE writes a register the ID instruction reads.
    // $0 is hard-wired to zero and never creates a dependency.
    function automatic logic load_use_hit(
        input logic             mem_read,
        input logic [REG_W-1:0] exe_rd,
        input logic [REG_W-1:0] id_rs,
        input logic [REG_W-1:0] id_rt,
        input logic             use_rt
    );
        return mem_read && (exe_rd != '0) &&
               ((exe_rd == id_rs) || (use_rt && (exe_rd == id_rt)));
    endfunction

endpackage

// File: rtl/hazard_ctrl_mdu_latency_cnt.sv
// -----------------------------------------------------------------------------
// mdu_latency_cnt
//   Down-counter tracking the remaining multiply/divide latency.
//   Ports:
//     clk, rst   : clock, synchronous active-high reset (count -> 0)
//     load       : load load_val (has priority over dec)
//     load_val   : value to load
//     dec        : decrement by one, saturating at zero
//     zero       : count is zero
// -----------------------------------------------------------------------------
module mdu_latency_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline hazard controller: generates stage stall/flush controls for
//   data-memory waits, multi-cycle mult/div, taken branches and load-use.
//   Priority: memory freeze > MDU > branch > load-use.
//
//   Parameters:
//     MDU_LAT     : mult/div latency in cycles (2..255)
//     MEM_TIMEOUT : consecutive frozen cycles after which mem_err is raised
//   Ports:
//     clk, rst                 : clock, synchronous active-high reset
//     ID_rs, ID_rt, ID_useRt   : source registers of the ID instruction
//     IDEXE_rd, IDEXE_memRead  : destination / load flag in ID/EXE
//     EXE_branchTaken          : EXE redirects the PC
//     EXE_mduStart             : EXE holds a mult/div
//     mem_req, mem_ready       : data-memory access and completion
//     *_stall / *_flush        : hold stage / load NOP into stage
//     mdu_busy                 : a mult/div is outstanding
//     mem_err                  : sticky memory timeout flag
//
//   Stall/flush outputs are combinational from state and current inputs and
//   are forced low while rst is high. The wait counter counts frozen cycles
//   including the first; when it reaches MEM_TIMEOUT, mem_err is set and the
//   FSM leaves MEM_WAIT.
// -----------------------------------------------------------------------------
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MDU_LAT     = MDU_LAT_DEF,
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] ID_rs,
    input  logic [REG_W-1:0] ID_rt,
    input  logic             ID_useRt,
    input  logic [REG_W-1:0] IDEXE_rd,
    input  logic             IDEXE_memRead,
    input  logic             EXE_branchTaken,
    input  logic             EXE_mduStart,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             PC_stall,
    output logic             IFID_stall,
    output logic             IDEXE_stall,
    output logic             EXEMEM_stall,
    output logic             IFID_flush,
    output logic             IDEXE_flush,
    output logic             EXEMEM_flush,
    output logic             mdu_busy,
    output logic             mem_err
);

    localparam int                 WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W:0]    TIMEOUT_V = (WAIT_W + 1)'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0]   MDU_LOAD  = CNT_W'(MDU_LAT - 1);

    hz_state_e         state_q, state_d;
    hz_state_e         ret_q, ret_d;      // state to resume after MEM_WAIT
    hz_state_e         eff_state;         // state whose rules apply this cycle
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [WAIT_W:0]   wait_inc;
    logic              mem_err_q, mem_err_d;

    logic freeze;
    logic load_use;
    logic cnt_load, cnt_dec, cnt_zero;

    logic pc_stall_c, ifid_stall_c, idexe_stall_c, exemem_stall_c;
    logic ifid_flush_c, idexe_flush_c, exemem_flush_c;

    mdu_latency_cnt #(
        .W (CNT_W)
    ) u_mdu_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (MDU_LOAD),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // While waiting on memory, the suspended state's rules still govern the
    // MDU countdown and the cycle on which the wait ends.
    assign eff_state = (state_q == ST_MEM_WAIT) ? ret_q : state_q;
    assign freeze    = mem_req & ~mem_ready;
    assign load_use  = load_use_hit(IDEXE_memRead, IDEXE_rd, ID_rs, ID_rt, ID_useRt);

    always_comb begin
        state_d        = state_q;
        ret_d          = ret_q;
        wait_d         = wait_q;
        mem_err_d      = mem_err_q;
        cnt_load       = 1'b0;
        cnt_dec        = 1'b0;
        pc_stall_c     = 1'b0;
        ifid_stall_c   = 1'b0;
        idexe_stall_c  = 1'b0;
        exemem_stall_c = 1'b0;
        ifid_flush_c   = 1'b0;
        idexe_flush_c  = 1'b0;
        exemem_flush_c = 1'b0;

        // Frozen cycles counted so far, including this one
        wait_inc = ((state_q == ST_MEM_WAIT) ? {1'b0, wait_q} : '0) + (WAIT_W + 1)'(1);

        if (freeze) begin
            pc_stall_c     = 1'b1;
            ifid_stall_c   = 1'b1;
            idexe_stall_c  = 1'b1;
            exemem_stall_c = 1'b1;
            // MDU keeps counting down (saturating) while memory holds the pipe
            cnt_dec        = (eff_state == ST_MDU_WAIT);
            ret_d          = eff_state;
            if (wait_inc >= TIMEOUT_V) begin
                mem_err_d = 1'b1;
                state_d   = eff_state;
                wait_d    = '0;
            end else begin
                state_d   = ST_MEM_WAIT;
                wait_d    = wait_inc[WAIT_W-1:0];
            end
        end else begin
            wait_d  = '0;
            state_d = eff_state;
            case (eff_state)
                ST_MDU_WAIT: begin
                    if (!cnt_zero) begin
                        pc_stall_c     = 1'b1;
                        ifid_stall_c   = 1'b1;
                        idexe_stall_c  = 1'b1;
                        exemem_flush_c = 1'b1;
                        cnt_dec        = 1'b1;
                    end else begin
                        // Result captured this cycle; pipeline proceeds
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    if (EXE_mduStart) begin
                        pc_stall_c     = 1'b1;
                        ifid_stall_c   = 1'b1;
                        idexe_stall_c  = 1'b1;
                        exemem_flush_c = 1'b1;
                        cnt_load       = 1'b1;
                        state_d        = ST_MDU_WAIT;
                    end else if (EXE_branchTaken) begin
                        // Branch wins over load-use: the dependent ID
                        // instruction is squashed, so no stall is needed.
                        ifid_flush_c  = 1'b1;
                        idexe_flush_c = 1'b1;
                    end else if (load_use) begin
                        pc_stall_c    = 1'b1;
                        ifid_stall_c  = 1'b1;
                        idexe_flush_c = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            ret_q     <= ST_RUN;
            wait_q    <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            wait_q    <= wait_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign PC_stall     = pc_stall_c     & ~rst;
    assign IFID_stall   = ifid_stall_c   & ~rst;
    assign IDEXE_stall  = idexe_stall_c  & ~rst;
    assign EXEMEM_stall = exemem_stall_c & ~rst;
    assign IFID_flush   = ifid_flush_c   & ~rst;
    assign IDEXE_flush  = idexe_flush_c  & ~rst;
    assign EXEMEM_flush = exemem_flush_c & ~rst;

    // Busy while a mult/div is outstanding, including while memory-frozen
    assign mdu_busy = (eff_state == ST_MDU_WAIT);
    assign mem_err  = mem_err_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//   Directed scenarios followed by random stimulus, each cycle compared with
//   a time-based reference: an MDU started at cycle t0 stalls until cycle
//   t0+MDU_LAT and completes on the first unfrozen cycle at or after it;
//   memory freezes are tracked as a run length of frozen cycles.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int MDU_LAT     = 4;
    localparam int MEM_TIMEOUT = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] ID_rs, ID_rt, IDEXE_rd;
    logic       ID_useRt, IDEXE_memRead, EXE_branchTaken, EXE_mduStart;
    logic       mem_req, mem_ready;
    logic       PC_stall, IFID_stall, IDEXE_stall, EXEMEM_stall;
    logic       IFID_flush, IDEXE_flush, EXEMEM_flush;
    logic       mdu_busy, mem_err;

    hazard_ctrl #(
        .MDU_LAT     (MDU_LAT),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .ID_rs           (ID_rs),
        .ID_rt           (ID_rt),
        .ID_useRt        (ID_useRt),
        .IDEXE_rd        (IDEXE_rd),
        .IDEXE_memRead   (IDEXE_memRead),
        .EXE_branchTaken (EXE_branchTaken),
        .EXE_mduStart    (EXE_mduStart),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .PC_stall        (PC_stall),
        .IFID_stall      (IFID_stall),
        .IDEXE_stall     (IDEXE_stall),
        .EXEMEM_stall    (EXEMEM_stall),
        .IFID_flush      (IFID_flush),
        .IDEXE_flush     (IDEXE_flush),
        .EXEMEM_flush    (EXEMEM_flush),
        .mdu_busy        (mdu_busy),
        .mem_err         (mem_err)
    );

    always #5 clk = ~clk;

    // Output vector order: PC, IFID, IDEXE, EXEMEM stall; IFID, IDEXE, EXEMEM flush
    localparam logic [6:0] O_NONE   = 7'b0000000;
    localparam logic [6:0] O_FREEZE = 7'b1111000;
    localparam logic [6:0] O_MDU    = 7'b1110001;
    localparam logic [6:0] O_BRANCH = 7'b0000110;
    localparam logic [6:0] O_LDUSE  = 7'b1100010;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model state
    bit m_mdu_on = 1'b0;
    int m_t0     = 0;
    int m_streak = 0;
    bit m_err    = 1'b0;

    // Last sampled DUT outputs
    logic [6:0] obs_o;
    logic       obs_busy, obs_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // One clock cycle: inputs are already driven; sample mid-cycle, compare
    // with the model, advance the model, then move just past the next edge.
    task automatic step(input string tag);
        logic [6:0] exp_o;
        bit frz, lu;
        @(negedge clk);
        frz = mem_req && !mem_ready;
        lu  = IDEXE_memRead && (IDEXE_rd != 5'd0) &&
              ((IDEXE_rd == ID_rs) || (ID_useRt && (IDEXE_rd == ID_rt)));
        obs_o    = {PC_stall, IFID_stall, IDEXE_stall, EXEMEM_stall,
                    IFID_flush, IDEXE_flush, EXEMEM_flush};
        obs_busy = mdu_busy;
        obs_err  = mem_err;
        exp_o    = O_NONE;
        if (rst) begin
            check({tag, "_rst_out"}, {25'd0, obs_o}, {25'd0, O_NONE});
            m_mdu_on = 1'b0;
            m_err    = 1'b0;
            m_streak = 0;
        end else begin
            check({tag, "_status"}, {30'd0, obs_busy, obs_err}, {30'd0, m_mdu_on, m_err});
            if (frz) begin
                exp_o = O_FREEZE;
                m_streak++;
                if (m_streak >= MEM_TIMEOUT) begin
                    m_err    = 1'b1;
                    m_streak = 0;
                end
            end else begin
                m_streak = 0;
                if (m_mdu_on) begin
                    if (cyc < m_t0 + MDU_LAT) exp_o = O_MDU;
                    else m_mdu_on = 1'b0;
                end else if (EXE_mduStart) begin
                    exp_o    = O_MDU;
                    m_mdu_on = 1'b1;
                    m_t0     = cyc;
                end else if (EXE_branchTaken) begin
                    exp_o = O_BRANCH;
                end else if (lu) begin
                    exp_o = O_LDUSE;
                end
            end
            check({tag, "_out"}, {25'd0, obs_o}, {25'd0, exp_o});
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        ID_rs = 5'd0; ID_rt = 5'd0; ID_useRt = 1'b0;
        IDEXE_rd = 5'd0; IDEXE_memRead = 1'b0;
        EXE_branchTaken = 1'b0; EXE_mduStart = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(0, 3))
            0:       return 5'd0;
            1:       return 5'd8;
            2:       return 5'd9;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    int n_stall, n_busy;

    initial begin
        idle_inputs();
        rst = 1'b1;

        // Reset
        step("reset");
        rst = 1'b0;
        step("idle");
        check("reset_outputs", {25'd0, obs_o}, {25'd0, O_NONE});
        check("reset_status", {30'd0, obs_busy, obs_err}, 32'd0);

        // Load-use via rs: exactly one bubble
        IDEXE_memRead = 1'b1; IDEXE_rd = 5'd8; ID_rs = 5'd8; ID_rt = 5'd3; ID_useRt = 1'b1;
        step("lu_rs");
        check("lu_rs_stall", {25'd0, obs_o}, {25'd0, O_LDUSE});
        IDEXE_memRead = 1'b0; IDEXE_rd = 5'd0;
        step("lu_bubble");
        check("lu_after_bubble", {25'd0, obs_o}, {25'd0, O_NONE});
        // Load into $0 never hazards
        IDEXE_memRead = 1'b1; IDEXE_rd = 5'd0; ID_rs = 5'd0; ID_rt = 5'd0;
        step("lu_r0");
        check("lu_r0_none", {25'd0, obs_o}, {25'd0, O_NONE});
        // Load-use via rt, only when rt is read
        IDEXE_rd = 5'd9; ID_rs = 5'd1; ID_rt = 5'd9; ID_useRt = 1'b1;
        step("lu_rt");
        check("lu_rt_stall", {25'd0, obs_o}, {25'd0, O_LDUSE});
        ID_useRt = 1'b0;
        step("lu_rt_unused");
        check("lu_rt_unused_none", {25'd0, obs_o}, {25'd0, O_NONE});
        idle_inputs();

        // MDU: start held in EXE while stalled, must be ignored
        EXE_mduStart = 1'b1;
        n_stall = 0; n_busy = 0;
        for (int k = 1; k <= 6; k++) begin
            if (k == 6) EXE_mduStart = 1'b0;
            step("mdu");
            n_stall += int'(obs_o[6]);
            n_busy  += int'(obs_busy);
            if (k == 5) check("mdu_capture_cycle", {25'd0, obs_o}, {25'd0, O_NONE});
            if (k == 6) check("mdu_run_after", {31'd0, obs_busy}, 32'd0);
        end
        check("mdu_stall_cycles", n_stall, MDU_LAT);
        check("mdu_busy_cycles", n_busy, MDU_LAT);

        // Branch coincident with load-use: flush only
        IDEXE_memRead = 1'b1; IDEXE_rd = 5'd8; ID_rs = 5'd8; EXE_branchTaken = 1'b1;
        step("br_lu");
        check("br_lu_flush", {25'd0, obs_o}, {25'd0, O_BRANCH});
        check("br_lu_pc_stall", {31'd0, obs_o[6]}, 32'd0);
        idle_inputs();

        // Memory ready after 3 frozen cycles
        mem_req = 1'b1; mem_ready = 1'b0;
        n_stall = 0;
        for (int k = 0; k < 3; k++) begin
            step("mem_wait");
            if (obs_o == O_FREEZE) n_stall++;
        end
        mem_ready = 1'b1;
        step("mem_ready");
        check("mem_ready_no_stall", {25'd0, obs_o}, {25'd0, O_NONE});
        check("mem_freeze_cycles", n_stall, 3);
        idle_inputs();
        step("mem_idle");

        // Memory never ready: timeout on the 64th frozen cycle
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int k = 1; k <= MEM_TIMEOUT; k++) begin
            step("mem_to");
            if (k == MEM_TIMEOUT) check("mem_err_before_edge", {31'd0, obs_err}, 32'd0);
        end
        idle_inputs();
        step("mem_to_after");
        check("mem_err_set", {31'd0, obs_err}, 32'd1);
        step("mem_err_sticky");
        check("mem_err_sticky", {31'd0, obs_err}, 32'd1);

        // Reset in the 2nd MDU cycle aborts and clears mem_err
        EXE_mduStart = 1'b1;
        step("mdu_rst_c1");
        rst = 1'b1;
        step("mdu_rst_c2");
        check("mdu_rst_outputs", {25'd0, obs_o}, {25'd0, O_NONE});
        rst = 1'b0; EXE_mduStart = 1'b0;
        step("mdu_rst_after");
        check("mdu_rst_after_out", {25'd0, obs_o}, {25'd0, O_NONE});
        check("mdu_rst_after_status", {30'd0, obs_busy, obs_err}, 32'd0);

        // Random traffic against the reference model
        for (int k = 0; k < 3000; k++) begin
            rst             = ($urandom_range(0, 199) == 0);
            ID_rs           = pick_reg();
            ID_rt           = pick_reg();
            ID_useRt        = 1'($urandom_range(0, 1));
            IDEXE_rd        = pick_reg();
            IDEXE_memRead   = 1'($urandom_range(0, 1));
            EXE_branchTaken = ($urandom_range(0, 99) < 15);
            EXE_mduStart    = ($urandom_range(0, 99) < 8);
            mem_req         = ($urandom_range(0, 99) < 25);
            mem_ready       = 1'($urandom_range(0, 1));
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
